// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM request controller.
// Holds default geometry, the controller state enum and byte-to-bit mask expansion.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W = 7;
  localparam int unsigned SRAM_DATA_W = 64;
  localparam int unsigned MASK_W_MAX  = 512;
  localparam int unsigned BE_W_MAX    = MASK_W_MAX / 8;

  typedef enum logic [0:0] {INIT, RUN} state_e;

  // Widest supported mask; callers zero-extend their strobes and truncate the result.
  function automatic logic [MASK_W_MAX-1:0] be_to_bitmask(input logic [BE_W_MAX-1:0] be);
    logic [MASK_W_MAX-1:0] mask;
    mask = '0;
    for (int k = 0; k < int'(BE_W_MAX); k++) begin
      mask[8*k +: 8] = {8{be[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO for read responses; depth need not be a power of two.
// No full/empty guarding: the controller's credit rule keeps push and pop legal.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = SRAM_DATA_W,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for a single-port SRAM with optional zero-fill after reset.
// Read data returns in order through a credit-limited response FIFO.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned DATA_W    = SRAM_DATA_W,
  parameter int unsigned RSP_DEPTH = 3,
  parameter int unsigned INIT_EN   = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_be,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_init_done,
  output logic                o_sram_cen,
  output logic                o_sram_wen,
  output logic [DATA_W-1:0]   o_sram_bit_mask,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [DATA_W-1:0]   o_sram_wdata,
  input  logic [DATA_W-1:0]   i_sram_rdata
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              inflight_q;
  logic [CNT_W-1:0]  rsp_count;
  logic [CNT_W:0]    credits_used;
  logic              credit_ok;
  logic              req_acc;
  logic              rd_acc;
  logic              rsp_pop;

  // A read in flight already owns a FIFO slot, so readiness depends only on registered state.
  assign credits_used = (CNT_W + 1)'(rsp_count) + (CNT_W + 1)'(inflight_q);
  assign credit_ok    = credits_used < (CNT_W + 1)'(RSP_DEPTH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= (INIT_EN != 0) ? INIT : RUN;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      inflight_q <= rd_acc;
    end
  end

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    o_req_ready     = 1'b0;
    req_acc         = 1'b0;
    o_sram_cen      = 1'b0;
    o_sram_wen      = 1'b0;
    o_sram_bit_mask = '0;
    o_sram_addr     = '0;
    o_sram_wdata    = '0;
    if (!i_rst) begin
      unique case (state_q)
        INIT: begin
          o_sram_cen      = 1'b1;
          o_sram_wen      = 1'b1;
          o_sram_bit_mask = '1;
          o_sram_addr     = init_cnt_q;
          init_cnt_d      = init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == '1) state_d = RUN;
        end
        RUN: begin
          o_req_ready  = credit_ok;
          req_acc      = i_req_valid && credit_ok;
          o_sram_cen   = req_acc;
          o_sram_wen   = req_acc && i_req_we;
          o_sram_addr  = i_req_addr;
          o_sram_wdata = i_req_wdata;
          if (req_acc && i_req_we) begin
            o_sram_bit_mask = DATA_W'(be_to_bitmask(BE_W_MAX'(i_req_be)));
          end
        end
      endcase
    end
  end

  assign rd_acc      = req_acc && !i_req_we;
  assign o_init_done = (state_q == RUN);
  assign o_rsp_valid = (rsp_count != '0);
  assign rsp_pop     = o_rsp_valid && i_rsp_ready;

  sram_rsp_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(RSP_DEPTH),
    .CNT_W(CNT_W)
  ) u_rsp_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (inflight_q),
    .wdata(i_sram_rdata),
    .pop  (rsp_pop),
    .rdata(o_rsp_rdata),
    .count(rsp_count)
  );

endmodule
